// File: rtl/rgmii_tx_speed_ctrl.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// rgmii_tx_speed_ctrl
//
// Classifies the measured RGMII RX clock frequency as 10M / 100M / 1000M,
// debounces the result over STABLE_COUNT measurement windows, and once locked
// generates the TX clock level and data-present strobe for that speed from the
// 125 MHz fabric clock.
//
// Optional feature: define RGMII_TX_SPEED_FORCE_EN to add a manual speed
// override (force_en / force_speed). Without it the block is purely automatic.
//
// Ports:
//   fabric_clk     in   125 MHz fabric clock (only clock)
//   rst            in   asynchronous active-high reset
//   rgmii_freq_hz  in   measured RX clock frequency, Hz
//   freq_valid     in   one-cycle strobe: new rgmii_freq_hz value
//   force_en       in   (RGMII_TX_SPEED_FORCE_EN only) override enable
//   force_speed    in   (RGMII_TX_SPEED_FORCE_EN only) override speed
//   link_speed     out  00 none, 01 10M, 10 100M, 11 1000M
//   speed_locked   out  high while locked
//   tx_gmii_mode   out  high at 1000M (TX clock forwarded from fabric_clk)
//   tx_clk_out     out  TX clock level for 10M / 100M
//   tx_data_en     out  one-cycle strobe: TX data presented
// -----------------------------------------------------------------------------
module rgmii_tx_speed_ctrl #(
   parameter int TOL_PCT      = 4,
   parameter int STABLE_COUNT = 3
) (
   input  logic        fabric_clk,
   input  logic        rst,
   input  logic [31:0] rgmii_freq_hz,
   input  logic        freq_valid,
`ifdef RGMII_TX_SPEED_FORCE_EN
   input  logic        force_en,
   input  logic [1:0]  force_speed,
`endif
   output logic [1:0]  link_speed,
   output logic        speed_locked,
   output logic        tx_gmii_mode,
   output logic        tx_clk_out,
   output logic        tx_data_en
);

   localparam logic [1:0] SPD_NONE = 2'b00;
   localparam logic [1:0] SPD_10   = 2'b01;
   localparam logic [1:0] SPD_100  = 2'b10;
   localparam logic [1:0] SPD_1000 = 2'b11;

   // Acceptance bands, computed in 64-bit to avoid overflow of nominal * 104.
   localparam logic [63:0] LO_PCT  = 64'(100 - TOL_PCT);
   localparam logic [63:0] HI_PCT  = 64'(100 + TOL_PCT);
   localparam logic [63:0] G_LO64  = 64'd125_000_000 * LO_PCT / 64'd100;
   localparam logic [63:0] G_HI64  = 64'd125_000_000 * HI_PCT / 64'd100;
   localparam logic [63:0] M_LO64  = 64'd25_000_000 * LO_PCT / 64'd100;
   localparam logic [63:0] M_HI64  = 64'd25_000_000 * HI_PCT / 64'd100;
   localparam logic [63:0] K_LO64  = 64'd2_500_000 * LO_PCT / 64'd100;
   localparam logic [63:0] K_HI64  = 64'd2_500_000 * HI_PCT / 64'd100;
   localparam logic [31:0] G_LO    = G_LO64[31:0];
   localparam logic [31:0] G_HI    = G_HI64[31:0];
   localparam logic [31:0] M_LO    = M_LO64[31:0];
   localparam logic [31:0] M_HI    = M_HI64[31:0];
   localparam logic [31:0] K_LO    = K_LO64[31:0];
   localparam logic [31:0] K_HI    = K_HI64[31:0];

   localparam int          CNT_W    = ($clog2(STABLE_COUNT + 1) < 1) ? 1 : $clog2(STABLE_COUNT + 1);
   localparam logic [31:0] STABLE_U = 32'(STABLE_COUNT);

   localparam logic [5:0]  DIV_LIM_100 = 6'd4;
   localparam logic [5:0]  DIV_LIM_10  = 6'd49;
   localparam logic [5:0]  DIV_HI_100  = 6'd2;
   localparam logic [5:0]  DIV_HI_10   = 6'd24;

   typedef enum logic [1:0] {
      NO_LINK   = 2'd0,
      CANDIDATE = 2'd1,
      LOCKED    = 2'd2
   } state_t;

   function automatic logic [1:0] classify(input logic [31:0] f);
      if (f >= G_LO && f <= G_HI)      return SPD_1000;
      else if (f >= M_LO && f <= M_HI) return SPD_100;
      else if (f >= K_LO && f <= K_HI) return SPD_10;
      else                             return SPD_NONE;
   endfunction

   state_t           state;
   logic [1:0]       cand;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] miss;
   logic [1:0]       fsm_spd;     // speed the FSM is locked at, 00 when not locked

   logic [1:0]       cls;
   logic             lock_evt;
   logic             drop_evt;
   logic [1:0]       fsm_spd_nxt;

   logic [5:0]       div;
   logic [5:0]       div_nxt;
   logic [5:0]       div_lim;
   logic [1:0]       eff_spd;
   logic             restart;

   assign cls = classify(rgmii_freq_hz);

   // The strobe that completes the count; with STABLE_COUNT <= 1 the first
   // valid class locks straight from NO_LINK.
   always_comb begin
      lock_evt = 1'b0;
      drop_evt = 1'b0;
      if (freq_valid && cls != SPD_NONE) begin
         if (state == NO_LINK && STABLE_U <= 32'd1)
            lock_evt = 1'b1;
         if (state == CANDIDATE && cls == cand && (32'(cnt) + 32'd1) >= STABLE_U)
            lock_evt = 1'b1;
      end
      if (freq_valid && state == LOCKED && cls != fsm_spd && (32'(miss) + 32'd1) >= STABLE_U)
         drop_evt = 1'b1;
   end

   assign fsm_spd_nxt = lock_evt ? cls : (drop_evt ? SPD_NONE : fsm_spd);

   // Debounce FSM
   always_ff @(posedge fabric_clk or posedge rst) begin
      if (rst) begin
         state   <= NO_LINK;
         cand    <= SPD_NONE;
         cnt     <= '0;
         miss    <= '0;
         fsm_spd <= SPD_NONE;
      end else if (freq_valid) begin
         case (state)
            NO_LINK: begin
               if (cls != SPD_NONE) begin
                  if (lock_evt) begin
                     state   <= LOCKED;
                     fsm_spd <= cls;
                     cnt     <= '0;
                     miss    <= '0;
                  end else begin
                     state <= CANDIDATE;
                     cand  <= cls;
                     cnt   <= CNT_W'(1);
                  end
               end
            end
            CANDIDATE: begin
               if (cls == SPD_NONE) begin
                  state <= NO_LINK;
                  cnt   <= '0;
               end else if (cls == cand) begin
                  if (lock_evt) begin
                     state   <= LOCKED;
                     fsm_spd <= cand;
                     cnt     <= '0;
                     miss    <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end else begin
                  cand <= cls;
                  cnt  <= CNT_W'(1);
               end
            end
            LOCKED: begin
               if (cls == fsm_spd) begin
                  miss <= '0;
               end else if (drop_evt) begin
                  state   <= NO_LINK;
                  fsm_spd <= SPD_NONE;
                  miss    <= '0;
                  cnt     <= '0;
               end else begin
                  miss <= miss + CNT_W'(1);
               end
            end
            default: begin
               state   <= NO_LINK;
               fsm_spd <= SPD_NONE;
            end
         endcase
      end
   end

`ifdef RGMII_TX_SPEED_FORCE_EN
   logic forcing;
   logic forcing_q;
   assign forcing = force_en && (force_speed != SPD_NONE);

   always_ff @(posedge fabric_clk or posedge rst) begin
      if (rst) forcing_q <= 1'b0;
      else     forcing_q <= forcing;
   end
`endif

   // Effective speed for the next cycle. Any change of speed (including the
   // entry to lock, which is a change from 00) restarts the divider at 0.
   always_comb begin
      eff_spd = fsm_spd_nxt;
      restart = 1'b0;
`ifdef RGMII_TX_SPEED_FORCE_EN
      if (forcing)
         eff_spd = force_speed;
      if (forcing_q && !forcing)
         restart = 1'b1;
`endif
      if (eff_spd != link_speed)
         restart = 1'b1;
      case (eff_spd)
         SPD_100: div_lim = DIV_LIM_100;
         SPD_10:  div_lim = DIV_LIM_10;
         default: div_lim = 6'd0;
      endcase
      if (eff_spd == SPD_NONE || restart || div >= div_lim)
         div_nxt = 6'd0;
      else
         div_nxt = div + 6'd1;
   end

   // Registered TX outputs, all derived from the next-cycle divider phase
   always_ff @(posedge fabric_clk or posedge rst) begin
      if (rst) begin
         div          <= 6'd0;
         link_speed   <= SPD_NONE;
         speed_locked <= 1'b0;
         tx_gmii_mode <= 1'b0;
         tx_clk_out   <= 1'b0;
         tx_data_en   <= 1'b0;
      end else begin
         div          <= div_nxt;
         link_speed   <= eff_spd;
         speed_locked <= (eff_spd != SPD_NONE);
         tx_gmii_mode <= (eff_spd == SPD_1000);
         case (eff_spd)
            SPD_1000: begin
               tx_clk_out <= 1'b0;
               tx_data_en <= 1'b1;
            end
            SPD_100: begin
               tx_clk_out <= (div_nxt <= DIV_HI_100);
               tx_data_en <= (div_nxt == 6'd0);
            end
            SPD_10: begin
               tx_clk_out <= (div_nxt <= DIV_HI_10);
               tx_data_en <= (div_nxt == 6'd0);
            end
            default: begin
               tx_clk_out <= 1'b0;
               tx_data_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rgmii_tx_speed_ctrl.sv
`timescale 1ns / 1ps
module tb_rgmii_tx_speed_ctrl;

   localparam int TOL_PCT = 4;
   localparam int STABLE  = 3;

   logic        fabric_clk = 1'b0;
   logic        rst        = 1'b1;
   logic [31:0] rgmii_freq_hz = 32'd0;
   logic        freq_valid = 1'b0;
   logic [1:0]  link_speed;
   logic        speed_locked;
   logic        tx_gmii_mode;
   logic        tx_clk_out;
   logic        tx_data_en;
`ifdef RGMII_TX_SPEED_FORCE_EN
   logic        force_en    = 1'b0;
   logic [1:0]  force_speed = 2'b00;
`endif

   rgmii_tx_speed_ctrl #(.TOL_PCT(TOL_PCT), .STABLE_COUNT(STABLE)) dut (
      .fabric_clk    (fabric_clk),
      .rst           (rst),
      .rgmii_freq_hz (rgmii_freq_hz),
      .freq_valid    (freq_valid),
`ifdef RGMII_TX_SPEED_FORCE_EN
      .force_en      (force_en),
      .force_speed   (force_speed),
`endif
      .link_speed    (link_speed),
      .speed_locked  (speed_locked),
      .tx_gmii_mode  (tx_gmii_mode),
      .tx_clk_out    (tx_clk_out),
      .tx_data_en    (tx_data_en)
   );

   always #4 fabric_clk = ~fabric_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: lock status, locked speed, length of the current run of
   // agreeing windows, consecutive misses, and cycles elapsed since lock.
   bit m_locked;
   int m_speed;
   int run_cls;
   int run_len;
   int miss_cnt;
   int age;

   function automatic int classify_m(input longint f);
      longint noms[3] = '{125_000_000, 25_000_000, 2_500_000};
      int     codes[3] = '{3, 2, 1};
      for (int i = 0; i < 3; i++) begin
         if (f >= noms[i] * (100 - TOL_PCT) / 100 && f <= noms[i] * (100 + TOL_PCT) / 100)
            return codes[i];
      end
      return 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_locked = 0; m_speed = 0; run_cls = 0; run_len = 0; miss_cnt = 0; age = 0;
   endtask

   task automatic model_step(input bit v, input longint f);
      int c;
      if (m_locked) age++;
      if (!v) return;
      c = classify_m(f);
      if (!m_locked) begin
         if (c == 0) begin
            run_len = 0;
         end else begin
            if (run_len > 0 && c == run_cls) run_len++;
            else begin run_cls = c; run_len = 1; end
            if (run_len >= STABLE) begin
               m_locked = 1; m_speed = run_cls; age = 0; miss_cnt = 0; run_len = 0;
            end
         end
      end else begin
         if (c == m_speed) miss_cnt = 0;
         else begin
            miss_cnt++;
            if (miss_cnt >= STABLE) begin
               m_locked = 0; m_speed = 0; miss_cnt = 0; run_len = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      int e_spd, e_gm, e_clk, e_de, period, hi;
      e_spd = 0; e_gm = 0; e_clk = 0; e_de = 0;
      if (m_locked) begin
         e_spd = m_speed;
         if (m_speed == 3) begin
            e_gm = 1; e_de = 1;
         end else begin
            period = (m_speed == 2) ? 5 : 50;
            hi     = (m_speed == 2) ? 3 : 25;
            e_clk  = ((age % period) < hi) ? 1 : 0;
            e_de   = ((age % period) == 0) ? 1 : 0;
         end
      end
      check("link_speed",   link_speed,   e_spd);
      check("speed_locked", speed_locked, m_locked ? 1 : 0);
      check("tx_gmii_mode", tx_gmii_mode, e_gm);
      check("tx_clk_out",   tx_clk_out,   e_clk);
      check("tx_data_en",   tx_data_en,   e_de);
   endtask

   // Drive inputs, let one edge pass, advance the model, compare 1 ns later.
   task automatic tick(input bit v, input longint f);
      freq_valid    = v;
      rgmii_freq_hz = 32'(f);
      @(posedge fabric_clk);
      model_step(v, f);
      #1;
      compare_all();
   endtask

   task automatic strobe(input longint f, input int gap);
      tick(1, f);
      for (int g = 0; g < gap; g++) tick(0, longint'($urandom));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      freq_valid = 1'b0;
      @(posedge fabric_clk);
      model_reset();
      #1;
      check("rst_link_speed",   link_speed,   0);
      check("rst_speed_locked", speed_locked, 0);
      check("rst_tx_gmii_mode", tx_gmii_mode, 0);
      check("rst_tx_clk_out",   tx_clk_out,   0);
      check("rst_tx_data_en",   tx_data_en,   0);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pat[5] = '{1, 1, 1, 0, 0};
      longint edge_f[4]   = '{130_000_000, 130_000_001, 2_400_000, 2_399_999};
      int     edge_exp[4] = '{3, 0, 1, 0};
      longint target;
      longint jit;
      model_reset();

      // 1G lock
      do_reset();
      strobe(125_000_000, 2);
      strobe(125_000_000, 2);
      check("g_prelock", speed_locked, 0);
      tick(1, 125_000_000);
      check("g_link_speed", link_speed, 3);
      check("g_locked", speed_locked, 1);
      for (int i = 0; i < 8; i++) begin
         tick(0, 0);
         check("g_data_en", tx_data_en, 1);
      end

      // 100M lock and waveform
      do_reset();
      strobe(25_000_000, 3);
      strobe(25_000_000, 1);
      tick(1, 25_000_000);
      check("m_link_speed", link_speed, 2);
      for (int i = 0; i < 12; i++) begin
         if (i > 0) tick(0, longint'($urandom));
         check("m_clk_pat", tx_clk_out, pat[i % 5]);
         check("m_de_pat",  tx_data_en, (i % 5 == 0) ? 1 : 0);
      end

      // 10M lock, miss clearing, loss of lock
      do_reset();
      for (int i = 0; i < 3; i++) strobe(2_500_000, 4);
      check("k_link_speed", link_speed, 1);
      strobe(0, 2);
      strobe(0, 2);
      strobe(2_500_000, 2);
      check("k_keep1", speed_locked, 1);
      strobe(0, 2);
      strobe(0, 2);
      check("k_keep2", speed_locked, 1);
      tick(1, 0);
      check("k_drop_speed", link_speed, 0);
      check("k_drop_clk", tx_clk_out, 0);
      check("k_drop_de", tx_data_en, 0);
      check("k_drop_gm", tx_gmii_mode, 0);
      for (int i = 0; i < 6; i++) tick(0, 2_500_000);

      // Band edges
      for (int e = 0; e < 4; e++) begin
         do_reset();
         for (int i = 0; i < 3; i++) strobe(edge_f[e], 1);
         check("edge_speed", link_speed, edge_exp[e]);
      end

      // Candidate switching
      do_reset();
      strobe(125_000_000, 1);
      strobe(125_000_000, 1);
      strobe(25_000_000, 1);
      strobe(25_000_000, 1);
      check("cand_prelock", speed_locked, 0);
      tick(1, 25_000_000);
      check("cand_lock", link_speed, 2);

      // Asynchronous reset mid-period at 100M
      for (int i = 0; i < 7; i++) tick(0, 0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_speed",  link_speed,   0);
      check("arst_locked", speed_locked, 0);
      check("arst_gm",     tx_gmii_mode, 0);
      check("arst_clk",    tx_clk_out,   0);
      check("arst_de",     tx_data_en,   0);
      model_reset();
      @(posedge fabric_clk);
      #1;
      rst = 1'b0;
      strobe(125_000_000, 1);
      strobe(125_000_000, 1);
      check("arst_nolink", speed_locked, 0);
      tick(1, 125_000_000);
      check("arst_relock", link_speed, 3);

      // Randomized run against the model
      do_reset();
      target = 25_000_000;
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            case ($urandom_range(0, 4))
               0: target = 125_000_000;
               1: target = 25_000_000;
               2: target = 2_500_000;
               3: target = 0;
               default: target = longint'($urandom);
            endcase
         end
         if ($urandom_range(0, 9) == 0)
            jit = longint'($urandom);
         else if (target == 0)
            jit = 0;
         else
            jit = target - target * 3 / 100 + longint'($urandom_range(0, 32'(target * 6 / 100)));
         tick(($urandom_range(0, 3) == 0), jit);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
